if_id_instr_queue: RTL
======================

// Module: if_id_instr_queue
//
// PURPOSE
// - Decoupling FIFO between the IF stage and the ID stage. It absorbs fetched instructions when ID stalls and
//   presents them to ID in order.
// - Each entry holds IF_PC, IF_Instr (cpu_ibus.rdata), IF_ExceptType and the BPU prediction bits (IF_PResult).
//   All fields pass through unmodified.
// - A flush from branch resolution or an exception empties the queue, so no wrong-path fetch reaches decode.
//
// PARAMETERS
// - DEPTH    4   entry count; power of two, >= 2
// - EXC_W    8   width of the packed exception-type field
// - PRED_W   34  width of the packed branch-prediction field
//
// PORTS
// - clk          in   1              rising-edge clock
// - resetn       in   1              asynchronous, active-low reset
// - flush        in   1              discard all entries (IF_Flush / ID flush)
// - enq_valid    in   1              IF presents a valid fetched instruction
// - enq_ready    out  1              queue accepts the entry this cycle
// - enq_pc       in   32             IF_PC
// - enq_instr    in   32             IF_Instr
// - enq_except   in   EXC_W          IF_ExceptType
// - enq_pred     in   PRED_W         IF_PResult
// - deq_valid    out  1              head entry valid for ID
// - deq_ready    in   1              ID consumes head this cycle (ID_Wr)
// - deq_pc       out  32             head PC
// - deq_instr    out  32             head instruction
// - deq_except   out  EXC_W          head exception type
// - deq_pred     out  PRED_W         head prediction result
// - count        out  $clog2(DEPTH)+1  occupied entries
//
// BEHAVIOUR
// - Reset (resetn=0, async): rd_ptr=wr_ptr=0, count=0, deq_valid=0, all storage cleared.
// - While reset is asserted, enq_ready=0.
// - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. count is tracked separately; full is count==DEPTH.
// - Enqueue fires when enq_valid & enq_ready. The entry is written at wr_ptr on the rising edge and wr_ptr is incremented.
// - Dequeue fires when deq_valid & deq_ready. rd_ptr is incremented on the rising edge.
// - enq_ready = !full & !flush. A full queue refuses enqueue even if a dequeue happens in the same cycle;
//   no same-cycle full pass-through.
// - deq_valid = (count!=0) & !flush. deq_* come combinationally from the entry at rd_ptr.
// - When deq_valid=0, deq_pc, deq_instr, deq_except and deq_pred are driven to 0.
// - Simultaneous enqueue and dequeue with 0<count<DEPTH: count is unchanged and both pointers advance.
// - Flush is synchronous and has priority:
//   - on the edge with flush=1, count becomes 0 and rd_ptr becomes wr_ptr;
//   - any enqueue or dequeue presented in that cycle is ignored;
//   - the queue accepts again on the cycle after flush deasserts.
// - Latency (without bypass): an entry enqueued at edge N is visible at the head at the earliest in cycle N+1.
// - Throughput: one entry per cycle in steady state.
// - Entries carrying a nonzero except field are queued and delivered like any other entry. ID and MEM act on them;
//   the queue never drops or reorders them.
// - Data held at the head is stable while deq_valid=1 and deq_ready=0.
//
// CONFIGURATION
// - IQ_BYPASS_EN defined:
//   - when count==0, enq_valid=1, flush=0 and deq_ready=1, the incoming entry drives deq_* and deq_valid=1
//     in the same cycle;
//   - enq_ready=1 in that case, and the entry is consumed without being written (pointers and count unchanged);
//   - if deq_ready=0 in that case, the entry is written normally and is also shown on deq_* (deq_valid=1).
// - IQ_BYPASS_EN undefined: no bypass path; minimum IF-to-ID latency is one cycle through storage.
//
// TESTING
// - T1: reset, then enq 3 entries (pc 0xBFC00000/04/08), deq_ready=0 -> count=3, deq_pc=0xBFC00000, deq_valid=1.
// - T2: fill to DEPTH=4 -> enq_ready=0. Hold enq_valid=1 with deq_ready=1 for 1 cycle -> count=3;
//   the entry presented while full is not accepted.
// - T3: stream 10 entries, enq_valid=deq_ready=1 for 10 cycles -> ID sees pcs in order, count stays 1
//   (0 with IQ_BYPASS_EN), pointer wrap is exercised.
// - T4: count=2, assert flush for 1 cycle with enq_valid=1 -> deq_valid=0 during the flush, count=0 after the edge,
//   the flushed-cycle entry is absent afterwards.
// - T5: enqueue an entry with enq_except=0x04 and instr=0x00000000 -> delivered with deq_except=0x04;
//   the following entry is delivered next, unchanged.
// - T6: assert resetn=0 mid-cycle with count=3 -> count=0 and deq_valid=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/if_id_instr_queue.sv
// IF-to-ID instruction queue: in-order FIFO of fetched PC/instruction/exception/prediction entries with flush.
// Optional same-cycle empty-queue bypass from IF to ID is enabled by defining IQ_BYPASS_EN.
module if_id_instr_queue #(
    parameter int DEPTH  = 4,
    parameter int EXC_W  = 8,
    parameter int PRED_W = 34
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [31:0]                enq_pc,
    input  logic [31:0]                enq_instr,
    input  logic [EXC_W-1:0]           enq_except,
    input  logic [PRED_W-1:0]          enq_pred,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [31:0]                deq_pc,
    output logic [31:0]                deq_instr,
    output logic [EXC_W-1:0]           deq_except,
    output logic [PRED_W-1:0]          deq_pred,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count_q;

    logic [31:0]       mem_pc     [DEPTH];
    logic [31:0]       mem_instr  [DEPTH];
    logic [EXC_W-1:0]  mem_except [DEPTH];
    logic [PRED_W-1:0] mem_pred   [DEPTH];

    logic full;
    logic empty;
    logic byp_show;
    logic byp_take;
    logic enq_fire;
    logic deq_fire;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A full queue refuses even when the head drains this cycle.
    assign enq_ready = resetn & ~full & ~flush;

`ifdef IQ_BYPASS_EN
    assign byp_show = resetn & empty & enq_valid & ~flush;
`else
    assign byp_show = 1'b0;
`endif
    assign byp_take = byp_show & deq_ready;

    assign deq_valid = (~empty & ~flush) | byp_show;

    // Bypassed entries are consumed straight from IF and never stored.
    assign enq_fire = enq_valid & enq_ready & ~byp_take;
    assign deq_fire = ~empty & ~flush & deq_ready;

    always_comb begin
        deq_pc     = '0;
        deq_instr  = '0;
        deq_except = '0;
        deq_pred   = '0;
        if (byp_show) begin
            deq_pc     = enq_pc;
            deq_instr  = enq_instr;
            deq_except = enq_except;
            deq_pred   = enq_pred;
        end else if (deq_valid) begin
            deq_pc     = mem_pc[rd_ptr];
            deq_instr  = mem_instr[rd_ptr];
            deq_except = mem_except[rd_ptr];
            deq_pred   = mem_pred[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]     <= '0;
                mem_instr[i]  <= '0;
                mem_except[i] <= '0;
                mem_pred[i]   <= '0;
            end
        end else if (flush) begin
            count_q <= '0;
            rd_ptr  <= wr_ptr;
        end else begin
            if (enq_fire) begin
                mem_pc[wr_ptr]     <= enq_pc;
                mem_instr[wr_ptr]  <= enq_instr;
                mem_except[wr_ptr] <= enq_except;
                mem_pred[wr_ptr]   <= enq_pred;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;

endmodule
